// File: rtl/pkt_gen_task_sched_if.sv
// Config-write port and valid/ready task port of the packet-generator task scheduler.
// The master side (config host + task FIFO) drives writes and ready; the slave is the scheduler.
interface pkt_gen_task_sched_if #(
  parameter int FLOW_CNT_WIDTH = 4,
  parameter int SIZE_W         = 16
);
  logic [FLOW_CNT_WIDTH-1:0] wr_addr_i;
  logic [1:0]                wr_sel_i;
  logic [31:0]               wr_data_i;
  logic                      wr_en_i;
  logic [FLOW_CNT_WIDTH-1:0] task_flow_num_o;
  logic [SIZE_W-1:0]         task_pkt_size_o;
  logic                      task_valid_o;
  logic                      task_ready_i;

  modport master (
    output wr_addr_i, wr_sel_i, wr_data_i, wr_en_i, task_ready_i,
    input  task_flow_num_o, task_pkt_size_o, task_valid_o
  );

  modport slave (
    input  wr_addr_i, wr_sel_i, wr_data_i, wr_en_i, task_ready_i,
    output task_flow_num_o, task_pkt_size_o, task_valid_o
  );
endinterface

// File: rtl/pkt_gen_task_sched.sv
// Token-bucket task scheduler: per-flow saturating byte buckets refilled on a prescaled tick,
// served round-robin and offered to the task FIFO over a registered valid/ready port.
module pkt_gen_task_sched #(
  parameter int FLOW_CNT       = 16,
  parameter int SIZE_W         = 16,
  parameter int RATE_W         = 32,
  parameter int BUCKET_W       = 34,
  parameter int TICK_DIV       = 1,
  parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pkt_gen_task_sched_if.slave  bus
);

  localparam int FW  = FLOW_CNT_WIDTH;
  localparam int FW1 = FLOW_CNT_WIDTH + 1;
  localparam int BW1 = BUCKET_W + 1;
  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0]       TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]       TICK_ONE   = TW'(1);
  localparam logic [FW-1:0]       FLOW_LAST  = FW'(FLOW_CNT - 1);
  localparam logic [FW-1:0]       PTR_ONE    = FW'(1);
  localparam logic [FW:0]         FLOW_CNT_X = FW1'(FLOW_CNT);
  localparam logic [BUCKET_W-1:0] BKT_MAX    = {BUCKET_W{1'b1}};

  typedef enum logic [0:0] {
    S_SCAN  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [FW-1:0]       ptr_q, ptr_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [FW-1:0]       flow_q, flow_d;
  logic [SIZE_W-1:0]   psize_q, psize_d;
  logic                valid_q, valid_d;

  logic [SIZE_W-1:0]   size_q   [FLOW_CNT];
  logic [SIZE_W-1:0]   size_d   [FLOW_CNT];
  logic [RATE_W-1:0]   rate_q   [FLOW_CNT];
  logic [RATE_W-1:0]   rate_d   [FLOW_CNT];
  logic                en_q     [FLOW_CNT];
  logic                en_d     [FLOW_CNT];
  logic [BUCKET_W-1:0] bucket_q [FLOW_CNT];
  logic [BUCKET_W-1:0] bucket_d [FLOW_CNT];

  logic                clr_s    [FLOW_CNT];
  logic [BUCKET_W-1:0] fill_s   [FLOW_CNT];

  logic                tick_s;
  logic                wr_hit_s;
  logic                hs_s;
  logic                eligible_s;
  logic [FW-1:0]       ptr_next_s;

  function automatic logic [BUCKET_W-1:0] sat_add(input logic [BUCKET_W-1:0] b,
                                                  input logic [RATE_W-1:0]   r);
    logic [BUCKET_W:0] sum;
    sum = {1'b0, b} + BW1'(r);
    if (sum[BUCKET_W]) begin
      sat_add = BKT_MAX;
    end else begin
      sat_add = sum[BUCKET_W-1:0];
    end
  endfunction

  function automatic logic [BUCKET_W-1:0] floor_sub(input logic [BUCKET_W-1:0] b,
                                                    input logic [SIZE_W-1:0]   s);
    logic [BUCKET_W-1:0] ext;
    ext = BUCKET_W'(s);
    if (b >= ext) begin
      floor_sub = b - ext;
    end else begin
      floor_sub = {BUCKET_W{1'b0}};
    end
  endfunction

  assign tick_s     = (tick_q == TICK_LAST);
  assign wr_hit_s   = bus.wr_en_i && ({1'b0, bus.wr_addr_i} < FLOW_CNT_X);
  assign hs_s       = (state_q == S_OFFER) && bus.task_ready_i;
  assign ptr_next_s = (ptr_q == FLOW_LAST) ? {FW{1'b0}} : (ptr_q + PTR_ONE);
  assign eligible_s = en_q[ptr_q] && (size_q[ptr_q] != {SIZE_W{1'b0}}) &&
                      (bucket_q[ptr_q] >= BUCKET_W'(size_q[ptr_q]));
  assign tick_d     = tick_s ? {TW{1'b0}} : (tick_q + TICK_ONE);

  // Per-flow config writes and bucket update: clear, then refill, then handshake deduction.
  always_comb begin
    for (int f = 0; f < FLOW_CNT; f++) begin
      size_d[f] = size_q[f];
      rate_d[f] = rate_q[f];
      en_d[f]   = en_q[f];
      clr_s[f]  = 1'b0;
      if (wr_hit_s && (bus.wr_addr_i == FW'(f))) begin
        case (bus.wr_sel_i)
          2'd0:    size_d[f] = SIZE_W'(bus.wr_data_i);
          2'd1:    rate_d[f] = RATE_W'(bus.wr_data_i);
          2'd2: begin
            en_d[f]  = bus.wr_data_i[0];
            clr_s[f] = ~bus.wr_data_i[0];
          end
          2'd3:    clr_s[f] = 1'b1;
          default: clr_s[f] = 1'b0;
        endcase
      end else begin
        clr_s[f] = 1'b0;
      end
      fill_s[f]   = clr_s[f] ? {BUCKET_W{1'b0}} : bucket_q[f];
      fill_s[f]   = (tick_s && en_d[f]) ? sat_add(fill_s[f], rate_q[f]) : fill_s[f];
      bucket_d[f] = (hs_s && (ptr_q == FW'(f))) ? floor_sub(fill_s[f], psize_q) : fill_s[f];
    end
  end

  // Scan/offer FSM; the offered flow and size are latched so config changes cannot disturb them.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    flow_d  = flow_q;
    psize_d = psize_q;
    valid_d = valid_q;
    case (state_q)
      S_SCAN: begin
        if (eligible_s) begin
          state_d = S_OFFER;
          flow_d  = ptr_q;
          psize_d = size_q[ptr_q];
          valid_d = 1'b1;
        end else begin
          ptr_d = ptr_next_s;
        end
      end
      S_OFFER: begin
        if (bus.task_ready_i) begin
          state_d = S_SCAN;
          valid_d = 1'b0;
          ptr_d   = ptr_next_s;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_SCAN;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, config and bucket registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_SCAN;
      ptr_q   <= {FW{1'b0}};
      tick_q  <= {TW{1'b0}};
      flow_q  <= {FW{1'b0}};
      psize_q <= {SIZE_W{1'b0}};
      valid_q <= 1'b0;
      for (int f = 0; f < FLOW_CNT; f++) begin
        size_q[f]   <= {SIZE_W{1'b0}};
        rate_q[f]   <= {RATE_W{1'b0}};
        en_q[f]     <= 1'b0;
        bucket_q[f] <= {BUCKET_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tick_q  <= tick_d;
      flow_q  <= flow_d;
      psize_q <= psize_d;
      valid_q <= valid_d;
      for (int f = 0; f < FLOW_CNT; f++) begin
        size_q[f]   <= size_d[f];
        rate_q[f]   <= rate_d[f];
        en_q[f]     <= en_d[f];
        bucket_q[f] <= bucket_d[f];
      end
    end
  end

  assign bus.task_valid_o    = valid_q;
  assign bus.task_flow_num_o = flow_q;
  assign bus.task_pkt_size_o = psize_q;

endmodule

// File: tb/tb_pkt_gen_task_sched.sv
// Self-checking bench for pkt_gen_task_sched: directed scenarios plus randomized traffic
// checked against a token-bucket reference model kept in the bench.
module tb_pkt_gen_task_sched;
  localparam int    N    = 16;
  localparam int    TD   = 1;
  localparam longint BMAX = 64'h3_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  pkt_gen_task_sched_if #(.FLOW_CNT_WIDTH(4), .SIZE_W(16)) bus_m ();
  pkt_gen_task_sched_if #(.FLOW_CNT_WIDTH(2), .SIZE_W(16)) bus_s ();

  pkt_gen_task_sched #(.FLOW_CNT(16), .TICK_DIV(1)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus_m)
  );
  pkt_gen_task_sched #(.FLOW_CNT(4), .TICK_DIV(4)) dut_sat (
    .clk_i(clk), .rst_i(rst_s), .bus(bus_s)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: buckets as plain integers, one offered task at a time, pointer round-robin.
  int unsigned m_size [N];
  int unsigned m_rate [N];
  bit          m_en   [N];
  longint      m_bkt  [N];
  longint      m_nb   [N];
  bit          m_en_n [N];
  int          m_ptr, m_tick, m_flow, m_psize;
  bit          m_offer, m_hs, m_tk, m_clr;

  always @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < N; f++) begin
        m_size[f] = 0; m_rate[f] = 0; m_en[f] = 1'b0; m_bkt[f] = 0;
      end
      m_ptr = 0; m_tick = 0; m_flow = 0; m_psize = 0; m_offer = 1'b0;
    end else begin
      m_hs = m_offer && bus_m.task_ready_i;
      m_tk = (m_tick == TD - 1);
      for (int f = 0; f < N; f++) begin
        m_en_n[f] = m_en[f];
        m_clr = 1'b0;
        if (bus_m.wr_en_i && bus_m.wr_addr_i == f) begin
          if (bus_m.wr_sel_i == 2) begin
            m_en_n[f] = bus_m.wr_data_i[0];
            m_clr = !bus_m.wr_data_i[0];
          end
          if (bus_m.wr_sel_i == 3) m_clr = 1'b1;
        end
        m_nb[f] = m_clr ? 0 : m_bkt[f];
        if (m_tk && m_en_n[f]) m_nb[f] = m_nb[f] + longint'(m_rate[f]);
        if (m_nb[f] > BMAX) m_nb[f] = BMAX;
        if (m_hs && f == m_flow) m_nb[f] = (m_nb[f] > m_psize) ? m_nb[f] - m_psize : 0;
      end
      if (!m_offer) begin
        if (m_en[m_ptr] && m_size[m_ptr] != 0 && m_bkt[m_ptr] >= m_size[m_ptr]) begin
          m_offer = 1'b1; m_flow = m_ptr; m_psize = int'(m_size[m_ptr]);
        end else begin
          m_ptr = (m_ptr + 1) % N;
        end
      end else if (m_hs) begin
        m_offer = 1'b0; m_ptr = (m_flow + 1) % N;
      end
      if (bus_m.wr_en_i) begin
        if (bus_m.wr_sel_i == 0) m_size[bus_m.wr_addr_i] = {16'd0, bus_m.wr_data_i[15:0]};
        if (bus_m.wr_sel_i == 1) m_rate[bus_m.wr_addr_i] = bus_m.wr_data_i;
      end
      for (int f = 0; f < N; f++) begin
        m_en[f] = m_en_n[f]; m_bkt[f] = m_nb[f];
      end
      m_tick = (m_tick + 1) % TD;
    end
  end

  task automatic cfg(input int a, input int sel, input logic [31:0] d);
    @(negedge clk);
    bus_m.wr_en_i = 1'b1; bus_m.wr_addr_i = 4'(a); bus_m.wr_sel_i = 2'(sel); bus_m.wr_data_i = d;
    @(negedge clk);
    bus_m.wr_en_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus_m.task_ready_i = 1'b0; bus_m.wr_en_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus_m.task_valid_o !== 1'b0 || bus_m.task_flow_num_o !== 4'd0 || bus_m.task_pkt_size_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b f=%0d s=%0d expected 0/0/0",
               bus_m.task_valid_o, bus_m.task_flow_num_o, bus_m.task_pkt_size_o);
    end
    bad = 0;
    for (int f = 0; f < N; f++) if (dut.bucket_q[f] !== 34'd0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_buckets: got %0d nonzero expected 0", bad); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int bad_v, bad_o;
    bad_v = 0; bad_o = 0;
    bus_m.task_ready_i = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus_m.task_valid_o !== 1'b0) bad_v++;
      if (bus_m.task_flow_num_o !== 4'd0 || bus_m.task_pkt_size_o !== 16'd0) bad_o++;
    end
    checks++;
    if (bad_v != 0) begin errors++; $display("FAIL idle_valid: got %0d valid cycles expected 0", bad_v); end
    checks++;
    if (bad_o != 0) begin errors++; $display("FAIL idle_outputs: got %0d nonzero cycles expected 0", bad_o); end
  endtask

  task automatic test_single_flow();
    int tasks, bad_o, bad_m, bad_b;
    tasks = 0; bad_o = 0; bad_m = 0; bad_b = 0;
    do_reset();
    cfg(3, 0, 32'd100); cfg(3, 1, 32'd25);
    bus_m.task_ready_i = 1'b1;
    cfg(3, 2, 32'd1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus_m.task_valid_o !== m_offer) bad_m++;
      if (dut.bucket_q[3] !== 34'(m_bkt[3])) bad_b++;
      if (bus_m.task_valid_o === 1'b1) begin
        tasks++;
        if (bus_m.task_flow_num_o !== 4'd3 || bus_m.task_pkt_size_o !== 16'd100) bad_o++;
      end
    end
    checks++;
    if (bad_o != 0) begin errors++; $display("FAIL single_task_fields: got %0d bad tasks expected 0", bad_o); end
    checks++;
    if (bad_m != 0) begin errors++; $display("FAIL single_valid_model: got %0d diffs expected 0", bad_m); end
    checks++;
    if (bad_b != 0) begin errors++; $display("FAIL single_bucket_model: got %0d diffs expected 0", bad_b); end
    checks++;
    if (tasks * 100 > 25 * 400 || tasks < 400 / (N + 2) - 2) begin
      errors++; $display("FAIL single_task_rate: got %0d tasks expected %0d..%0d", tasks, 400 / (N + 2) - 2, 100);
    end
  endtask

  task automatic test_round_robin();
    int n, prev, bad_f, bad_a, bad_m;
    n = 0; prev = -1; bad_f = 0; bad_a = 0; bad_m = 0;
    do_reset();
    cfg(0, 0, 32'd10); cfg(0, 1, 32'd1000); cfg(5, 0, 32'd10); cfg(5, 1, 32'd1000);
    bus_m.task_ready_i = 1'b1;
    cfg(0, 2, 32'd1); cfg(5, 2, 32'd1);
    for (int i = 0; i < 300 && n < 8; i++) begin
      @(negedge clk);
      if (bus_m.task_valid_o !== m_offer) bad_m++;
      if (bus_m.task_valid_o === 1'b1) begin
        if (bus_m.task_flow_num_o !== 4'd0 && bus_m.task_flow_num_o !== 4'd5) bad_f++;
        if (int'(bus_m.task_flow_num_o) == prev) bad_a++;
        prev = int'(bus_m.task_flow_num_o);
        n++;
      end
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL rr_count: got %0d tasks expected 8", n); end
    checks++;
    if (bad_f != 0) begin errors++; $display("FAIL rr_flow_set: got %0d foreign flows expected 0", bad_f); end
    checks++;
    if (bad_a != 0) begin errors++; $display("FAIL rr_alternate: got %0d repeats expected 0", bad_a); end
    checks++;
    if (bad_m != 0) begin errors++; $display("FAIL rr_model: got %0d diffs expected 0", bad_m); end
  endtask

  task automatic test_stall();
    int bad, waited;
    bad = 0;
    do_reset();
    cfg(2, 0, 32'd64); cfg(2, 1, 32'd64); cfg(2, 2, 32'd1);
    waited = 0;
    while (bus_m.task_valid_o !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
    checks++;
    if (bus_m.task_flow_num_o !== 4'd2 || bus_m.task_pkt_size_o !== 16'd64 || bus_m.task_valid_o !== 1'b1) begin
      errors++; $display("FAIL stall_first_offer: got v=%0b f=%0d s=%0d expected 1/2/64",
                         bus_m.task_valid_o, bus_m.task_flow_num_o, bus_m.task_pkt_size_o);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_m.task_valid_o !== 1'b1 || bus_m.task_flow_num_o !== 4'd2 || bus_m.task_pkt_size_o !== 16'd64) bad++;
      bus_m.wr_en_i = (i == 20); bus_m.wr_addr_i = 4'd2; bus_m.wr_sel_i = 2'd0; bus_m.wr_data_i = 32'd128;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
    bus_m.task_ready_i = 1'b1;
    @(negedge clk);
    bus_m.task_ready_i = 1'b0;
    checks++;
    if (bus_m.task_valid_o !== 1'b0) begin errors++; $display("FAIL stall_gap: got valid=%0b expected 0", bus_m.task_valid_o); end
    waited = 0;
    while (bus_m.task_valid_o !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
    checks++;
    if (bus_m.task_valid_o !== 1'b1 || bus_m.task_flow_num_o !== 4'd2 || bus_m.task_pkt_size_o !== 16'd128) begin
      errors++; $display("FAIL stall_new_size: got v=%0b f=%0d s=%0d expected 1/2/128",
                         bus_m.task_valid_o, bus_m.task_flow_num_o, bus_m.task_pkt_size_o);
    end
  endtask

  task automatic test_disable_in_offer();
    int waited, extra;
    do_reset();
    cfg(1, 0, 32'd50); cfg(1, 1, 32'd50); cfg(1, 2, 32'd1);
    waited = 0;
    while (bus_m.task_valid_o !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
    cfg(1, 2, 32'd0);
    checks++;
    if (bus_m.task_valid_o !== 1'b1 || bus_m.task_flow_num_o !== 4'd1 || bus_m.task_pkt_size_o !== 16'd50) begin
      errors++; $display("FAIL dis_offer_kept: got v=%0b f=%0d s=%0d expected 1/1/50",
                         bus_m.task_valid_o, bus_m.task_flow_num_o, bus_m.task_pkt_size_o);
    end
    bus_m.task_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_m.task_valid_o !== 1'b0) begin errors++; $display("FAIL dis_handshake: got valid=%0b expected 0", bus_m.task_valid_o); end
    checks++;
    if (dut.bucket_q[1] !== 34'd0) begin errors++; $display("FAIL dis_bucket: got %0d expected 0", dut.bucket_q[1]); end
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_m.task_valid_o === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL dis_no_more: got %0d offers expected 0", extra); end
  endtask

  task automatic test_reset_in_offer();
    int waited, bad;
    do_reset();
    cfg(4, 0, 32'd8); cfg(4, 1, 32'd8); cfg(4, 2, 32'd1);
    waited = 0;
    while (bus_m.task_valid_o !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
    checks++;
    if (bus_m.task_valid_o !== 1'b1) begin errors++; $display("FAIL rstoff_offer: got valid=%0b expected 1", bus_m.task_valid_o); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_m.task_valid_o !== 1'b0 || bus_m.task_flow_num_o !== 4'd0 || bus_m.task_pkt_size_o !== 16'd0) begin
      errors++; $display("FAIL rstoff_outputs: got v=%0b f=%0d s=%0d expected 0/0/0",
                         bus_m.task_valid_o, bus_m.task_flow_num_o, bus_m.task_pkt_size_o);
    end
    bad = 0;
    for (int f = 0; f < N; f++) if (dut.bucket_q[f] !== 34'd0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstoff_buckets: got %0d nonzero expected 0", bad); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int bad_b;
    logic [1:0] sel;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (bus_m.task_valid_o !== m_offer ||
          (m_offer && (bus_m.task_flow_num_o !== 4'(m_flow) || bus_m.task_pkt_size_o !== 16'(m_psize)))) begin
        errors++; $display("FAIL rand_task @%0d: got v=%0b f=%0d s=%0d expected v=%0b f=%0d s=%0d", i,
                           bus_m.task_valid_o, bus_m.task_flow_num_o, bus_m.task_pkt_size_o, m_offer, m_flow, m_psize);
      end
      if (i % 250 == 249) begin
        bad_b = 0;
        for (int f = 0; f < N; f++) if (dut.bucket_q[f] !== 34'(m_bkt[f])) bad_b++;
        checks++;
        if (bad_b != 0) begin errors++; $display("FAIL rand_buckets @%0d: got %0d diffs expected 0", i, bad_b); end
      end
      bus_m.task_ready_i = ($urandom_range(0, 3) != 0);
      bus_m.wr_en_i      = ($urandom_range(0, 5) == 0);
      bus_m.wr_addr_i    = 4'($urandom_range(0, 15));
      sel                = 2'($urandom_range(0, 3));
      bus_m.wr_sel_i     = sel;
      case (sel)
        2'd0:    bus_m.wr_data_i = $urandom_range(0, 300);
        2'd1:    bus_m.wr_data_i = $urandom_range(0, 80);
        2'd2:    bus_m.wr_data_i = {$urandom_range(0, 7) != 0 ? 32'd1 : 32'd0} | 32'hA0;
        default: bus_m.wr_data_i = $urandom;
      endcase
    end
    bus_m.wr_en_i = 1'b0;
  endtask

  task automatic test_saturation();
    longint b, prev;
    int changes, bad, last, vbad;
    changes = 0; bad = 0; last = -1; vbad = 0; prev = 0; b = 0;
    @(negedge clk); rst_s = 1'b1;
    @(negedge clk); @(negedge clk); rst_s = 1'b0;
    bus_s.wr_en_i = 1'b1; bus_s.wr_addr_i = 2'd0; bus_s.wr_sel_i = 2'd1; bus_s.wr_data_i = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_s.wr_sel_i = 2'd2; bus_s.wr_data_i = 32'd1;
    @(negedge clk);
    bus_s.wr_en_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      b = longint'(dut_sat.bucket_q[0]);
      if (bus_s.task_valid_o !== 1'b0) vbad++;
      if (b != prev) begin
        changes++;
        if (b < prev) bad++;
        else if (b - prev != 64'hFFFF_FFFF && b != BMAX) bad++;
        if (last >= 0 && i - last != 4) bad++;
        last = i;
      end
      prev = b;
      @(negedge clk);
    end
    checks++;
    if (b != BMAX) begin errors++; $display("FAIL sat_final: got %0d expected %0d", b, BMAX); end
    checks++;
    if (changes != 5) begin errors++; $display("FAIL sat_steps: got %0d expected 5", changes); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sat_step_shape: got %0d bad steps expected 0", bad); end
    checks++;
    if (vbad != 0) begin errors++; $display("FAIL sat_no_valid: got %0d valid cycles expected 0", vbad); end
  endtask

  initial begin
    bus_m.wr_en_i = 1'b0; bus_m.wr_addr_i = 4'd0; bus_m.wr_sel_i = 2'd0; bus_m.wr_data_i = 32'd0;
    bus_m.task_ready_i = 1'b0;
    bus_s.wr_en_i = 1'b0; bus_s.wr_addr_i = 2'd0; bus_s.wr_sel_i = 2'd0; bus_s.wr_data_i = 32'd0;
    bus_s.task_ready_i = 1'b0;
    test_reset();
    test_idle();
    test_single_flow();
    test_round_robin();
    test_stall();
    test_disable_in_offer();
    test_reset_in_offer();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
